// File: rtl/event_timestamp_fifo.sv
// event_timestamp_fifo
//   Timestamps rising edges of an asynchronous event input with
//   {secondsSinceBoot, microsecondsSinceBoot} and queues them in a small
//   first-word-fall-through FIFO drained by the CPU. A sticky overflow flag
//   records events dropped while the FIFO was full.
//   Optional feature macro: EVENT_DEGLITCH_EN (qualify an event by holding
//   the synchronized input high for DEGLITCH_CYCLES cycles before writing).
module event_timestamp_fifo #(
  parameter int DEPTH_LOG2      = 2,
  parameter int DEGLITCH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           microsecondsSinceBoot,
  input  logic [31:0]           secondsSinceBoot,
  input  logic                  eventIn,
  input  logic                  rdStrobe,
  input  logic                  clearOverflow,
  output logic                  tsValid,
  output logic [31:0]           tsSeconds,
  output logic [31:0]           tsMicroseconds,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [31:0] sec;
    logic [31:0] usec;
  } ts_t;

  if (DEGLITCH_CYCLES < 2 || DEGLITCH_CYCLES > 255) begin : g_bad_deglitch
    $error("DEGLITCH_CYCLES must be in 2..255");
  end

  // ---------------------------------------------------------------------
  // Input synchronizer, edge detect and arming
  // ---------------------------------------------------------------------
  logic       sync1_q, sync2_q, sync3_q;
  logic       armed_q;
  // vld_pipe_q[1] means sync2_q holds a real sample of eventIn rather than
  // its reset value; arming waits for that so an input held high across
  // reset release is not mistaken for a fresh rising edge.
  logic [1:0] vld_pipe_q;
  logic       evt_edge;
  ts_t        cur_ts;

  assign cur_ts   = '{sec: secondsSinceBoot, usec: microsecondsSinceBoot};
  assign evt_edge = sync2_q & ~sync3_q & armed_q;

  // Two-flop synchronizer plus edge-history flop; arm once a real low is seen
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      armed_q    <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      sync1_q    <= eventIn;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
      if (vld_pipe_q[1] && !sync2_q) armed_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Capture: produces wr_req / wr_ts toward the FIFO
  // ---------------------------------------------------------------------
  logic wr_req;
  ts_t  wr_ts;

`ifdef EVENT_DEGLITCH_EN
  ts_t        pend_q;
  logic       pend_vld_q;
  logic [7:0] qual_q;

  // Write on the last qualifying cycle with the timestamp latched at the edge
  assign wr_req = pend_vld_q & sync2_q & ~evt_edge &
                  (qual_q == 8'(DEGLITCH_CYCLES - 1));
  assign wr_ts  = pend_q;

  // Pending timestamp and qualify counter; a new edge restarts qualification
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      qual_q     <= '0;
    end else if (evt_edge) begin
      pend_q     <= cur_ts;
      pend_vld_q <= 1'b1;
      qual_q     <= 8'd1;
    end else if (pend_vld_q) begin
      if (!sync2_q || qual_q == 8'(DEGLITCH_CYCLES - 1)) begin
        pend_vld_q <= 1'b0;
        qual_q     <= '0;
      end else begin
        qual_q     <= qual_q + 8'd1;
      end
    end
  end
`else
  // Every qualified edge is written at that same clock edge
  assign wr_req = evt_edge;
  assign wr_ts  = cur_ts;
`endif

  // ---------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------
  ts_t [DEPTH-1:0]        mem_q;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   empty, full, do_rd, do_wr, ovf_set;
  ts_t                    head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_rd   = rdStrobe & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_wr   = wr_req & (~full | do_rd);
  assign ovf_set = wr_req & full & ~do_rd;

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_wr && !do_rd)      count_d = count_q + CNT_ONE;
    else if (do_rd && !do_wr) count_d = count_q - CNT_ONE;
    if (ovf_set)            overflow_d = 1'b1;
    else if (clearOverflow) overflow_d = 1'b0;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage; contents are don't-care after reset so no reset here
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_ts;
  end

  assign head           = mem_q[rd_ptr_q];
  assign tsValid        = ~empty;
  assign tsSeconds      = empty ? 32'd0 : head.sec;
  assign tsMicroseconds = empty ? 32'd0 : head.usec;
  assign count          = count_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_event_timestamp_fifo.sv
// tb_event_timestamp_fifo
//   Scoreboarded bench: each driven event pushes its expected timestamp,
//   each read compares the FIFO head against the queue front.
module tb_event_timestamp_fifo;

`ifdef EVENT_DEGLITCH_EN
  localparam int WLAT = 2 + 4 - 1;
`else
  localparam int WLAT = 2;
`endif
  localparam int PLEN = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] usec = 32'd1000;
  logic [31:0] sec = 32'd0;
  logic        eventIn = 1'b0;
  logic        rdStrobe = 1'b0;
  logic        clearOverflow = 1'b0;
  logic        tsValid;
  logic [31:0] tsSeconds, tsMicroseconds;
  logic [2:0]  count;
  logic        overflow;

  int          cyc = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  logic [63:0] sb[$];

  event_timestamp_fifo #(.DEPTH_LOG2(2), .DEGLITCH_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .microsecondsSinceBoot(usec), .secondsSinceBoot(sec),
    .eventIn(eventIn), .rdStrobe(rdStrobe), .clearOverflow(clearOverflow),
    .tsValid(tsValid), .tsSeconds(tsSeconds), .tsMicroseconds(tsMicroseconds),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // cyc = index of the next rising edge as seen from the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  // Counter model value presented at rising edge n
  function automatic logic [63:0] exp_ts(input int n);
    return {32'(n / 16), 32'(1000 + 7 * n)};
  endfunction

  always @(negedge clk) {sec, usec} = exp_ts(cyc);

  task automatic pulse(input int len, input bit push);
    eventIn = 1'b1;
    if (push) sb.push_back(exp_ts(cyc + 2));
    repeat (len) @(negedge clk);
    eventIn = 1'b0;
    repeat (WLAT + 2) @(negedge clk);
  endtask

  task automatic rd_one();
    rdStrobe = 1'b1;
    @(negedge clk);
    rdStrobe = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({count, tsValid, overflow, tsSeconds, tsMicroseconds} !== {3'd0, 1'b0, 1'b0, 64'd0}) begin
      $display("FAIL reset_state: got cnt=%0d v=%b ovf=%b ts=%h_%h want all zero", count, tsValid, overflow, tsSeconds, tsMicroseconds);
    end else pass_cnt++;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    pulse(5, 1'b1);
    tot_cnt++;
    if (count !== 3'd1) $display("FAIL single_count: got %0d want 1", count);
    else pass_cnt++;
    tot_cnt++;
    if ({tsValid, tsSeconds, tsMicroseconds} !== {1'b1, sb[0]})
      $display("FAIL single_head: got v=%b %h_%h want 1 %h", tsValid, tsSeconds, tsMicroseconds, sb[0]);
    else pass_cnt++;
    void'(sb.pop_front());
    rd_one();
    tot_cnt++;
    if ({count, tsValid, tsSeconds, tsMicroseconds} !== {3'd0, 1'b0, 64'd0})
      $display("FAIL single_pop: got cnt=%0d v=%b %h_%h want empty zeros", count, tsValid, tsSeconds, tsMicroseconds);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) pulse(PLEN, 1'b1);
    tot_cnt++;
    if ({count, overflow} !== {3'd4, 1'b0}) $display("FAIL ovf_fill: got cnt=%0d ovf=%b want 4 0", count, overflow);
    else pass_cnt++;
    pulse(PLEN, 1'b0);
    tot_cnt++;
    if ({count, overflow} !== {3'd4, 1'b1}) $display("FAIL ovf_drop: got cnt=%0d ovf=%b want 4 1", count, overflow);
    else pass_cnt++;
    clearOverflow = 1'b1;
    @(negedge clk);
    clearOverflow = 1'b0;
    tot_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
    else pass_cnt++;
    while (sb.size() > 0) begin
      tot_cnt++;
      if ({tsValid, tsSeconds, tsMicroseconds} !== {1'b1, sb[0]})
        $display("FAIL ovf_order: got v=%b %h_%h want 1 %h", tsValid, tsSeconds, tsMicroseconds, sb[0]);
      else pass_cnt++;
      void'(sb.pop_front());
      rd_one();
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 4; i++) pulse(PLEN, 1'b1);
    eventIn = 1'b1;
    sb.push_back(exp_ts(cyc + 2));
    repeat (WLAT) @(negedge clk);
    tot_cnt++;
    if ({tsValid, tsSeconds, tsMicroseconds} !== {1'b1, sb[0]})
      $display("FAIL fullrw_head: got v=%b %h_%h want 1 %h", tsValid, tsSeconds, tsMicroseconds, sb[0]);
    else pass_cnt++;
    void'(sb.pop_front());
    rd_one();
    if (PLEN > WLAT + 1) repeat (PLEN - WLAT - 1) @(negedge clk);
    eventIn = 1'b0;
    repeat (WLAT + 2) @(negedge clk);
    tot_cnt++;
    if ({count, overflow} !== {3'd4, 1'b0}) $display("FAIL fullrw_cnt: got cnt=%0d ovf=%b want 4 0", count, overflow);
    else pass_cnt++;
    while (sb.size() > 0) begin
      tot_cnt++;
      if ({tsValid, tsSeconds, tsMicroseconds} !== {1'b1, sb[0]})
        $display("FAIL fullrw_order: got v=%b %h_%h want 1 %h", tsValid, tsSeconds, tsMicroseconds, sb[0]);
      else pass_cnt++;
      void'(sb.pop_front());
      rd_one();
    end
  endtask

  task automatic test_arming();
    eventIn = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    tot_cnt++;
    if ({count, tsValid} !== {3'd0, 1'b0}) $display("FAIL arm_held: got cnt=%0d v=%b want 0 0", count, tsValid);
    else pass_cnt++;
    eventIn = 1'b0;
    repeat (3) @(negedge clk);
    pulse(PLEN, 1'b1);
    tot_cnt++;
    if (count !== 3'd1) $display("FAIL arm_rise: got cnt=%0d want 1", count);
    else pass_cnt++;
    tot_cnt++;
    if ({tsValid, tsSeconds, tsMicroseconds} !== {1'b1, sb[0]})
      $display("FAIL arm_head: got v=%b %h_%h want 1 %h", tsValid, tsSeconds, tsMicroseconds, sb[0]);
    else pass_cnt++;
    void'(sb.pop_front());
    rd_one();
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 4; i++) pulse(PLEN, 1'b1);
    pulse(PLEN, 1'b0);
    rd_one();
    tot_cnt++;
    if ({count, overflow} !== {3'd3, 1'b1}) $display("FAIL mid_pre: got cnt=%0d ovf=%b want 3 1", count, overflow);
    else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    tot_cnt++;
    if ({count, tsValid, overflow, tsSeconds} !== {3'd0, 1'b0, 1'b0, 32'd0})
      $display("FAIL mid_reset: got cnt=%0d v=%b ovf=%b s=%h want 0 0 0 0", count, tsValid, overflow, tsSeconds);
    else pass_cnt++;
    rd_one();
    tot_cnt++;
    if ({count, tsValid, tsMicroseconds} !== {3'd0, 1'b0, 32'd0})
      $display("FAIL empty_rd: got cnt=%0d v=%b us=%h want 0 0 0", count, tsValid, tsMicroseconds);
    else pass_cnt++;
    repeat (4) @(negedge clk);
  endtask

`ifdef EVENT_DEGLITCH_EN
  task automatic test_deglitch();
    pulse(2, 1'b0);
    tot_cnt++;
    if (count !== 3'd0) $display("FAIL dg_short: got cnt=%0d want 0", count);
    else pass_cnt++;
    pulse(6, 1'b1);
    tot_cnt++;
    if ({count, tsValid, tsSeconds, tsMicroseconds} !== {3'd1, 1'b1, sb[0]})
      $display("FAIL dg_long: got cnt=%0d v=%b %h_%h want 1 1 %h", count, tsValid, tsSeconds, tsMicroseconds, sb[0]);
    else pass_cnt++;
    void'(sb.pop_front());
    rd_one();
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_full_rw();
    test_arming();
    test_midreset();
`ifdef EVENT_DEGLITCH_EN
    test_deglitch();
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
